// File: rtl/weight_update.sv
// weight_update: sign-error LMS coefficient update stage with tap delay line.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   x_in/x_valid      new input sample, shifted in when x_ready (IDLE)
//   x_ready           delay line accepts a sample
//   error/err_valid   error sample from the error stage
//   err_ready         engine idle; error accepted on err_valid & err_ready
//   w_addr/w_data     combinational coefficient read port, 0 beyond TAPS
//   busy              update pass in progress
//   update_done       one-cycle pulse at the end of a pass
// Optional build macro: WU_LEAKAGE_EN enables leaky LMS (w -= w >>> LEAK_SHIFT).
module weight_update #(
  parameter int WIDTH      = 16,
  parameter int TAPS       = 8,
  parameter int ADDR_W     = 3,
  parameter int MU_SHIFT   = 4,
  parameter int LEAK_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  x_in,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [WIDTH-1:0]  error,
  input  logic              err_valid,
  output logic              err_ready,
  input  logic [ADDR_W-1:0] w_addr,
  output logic [WIDTH-1:0]  w_data,
  output logic              busy,
  output logic              update_done
);
`ifdef WU_LEAKAGE_EN
  localparam int LEAK_ON = 1;
`else
  localparam int LEAK_ON = 0;
`endif
  // One guard bit for the delta sum, a second one when the leak term is also subtracted.
  localparam int SW = WIDTH + 1 + LEAK_ON;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0] TAPS_W = (ADDR_W + 1)'(TAPS);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0] sgn_q, sgn_d;
  logic signed [WIDTH-1:0] w_q [TAPS];
  logic signed [WIDTH-1:0] xd_q [TAPS];
  logic signed [WIDTH-1:0] w_sel, delta, w_new;
  logic signed [SW-1:0] lterm, dterm, sum;
  logic ovf, x_acc;
  assign x_ready = state_q == IDLE;
  assign err_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign update_done = state_q == DONE;
  assign x_acc = x_valid & x_ready;
  assign w_data = {1'b0, w_addr} < TAPS_W ? w_q[w_addr] : '0;
  always_comb begin
    w_sel = w_q[idx_q];
    delta = xd_q[idx_q] >>> MU_SHIFT;
    lterm = LEAK_ON != 0 ? SW'(w_sel >>> LEAK_SHIFT) : '0;
    // sgn_q is {positive, negative}; both clear means a zero error.
    dterm = sgn_q[1] ? SW'(delta) : sgn_q[0] ? -SW'(delta) : '0;
    sum = SW'(w_sel) - lterm + dterm;
    // In range only when all bits above the result sign agree with it.
    ovf = ~(&sum[SW-1:WIDTH-1] | ~|sum[SW-1:WIDTH-1]);
    w_new = ovf ? {sum[SW-1], {(WIDTH-1){~sum[SW-1]}}} : sum[WIDTH-1:0];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sgn_d = sgn_q;
    if (state_q == IDLE && err_valid) begin
      state_d = UPDATE;
      idx_d = '0;
      sgn_d = {~error[WIDTH-1] & |error, error[WIDTH-1]};
    end else if (state_q == UPDATE) begin
      idx_d = idx_q + 1'b1;
      state_d = idx_q == LAST ? DONE : UPDATE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      sgn_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        w_q[i] <= '0;
        xd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sgn_q <= sgn_d;
      if (x_acc) begin
        xd_q[0] <= x_in;
        for (int i = 1; i < TAPS; i++) xd_q[i] <= xd_q[i-1];
      end
      if (state_q == UPDATE) w_q[idx_q] <= w_new;
    end
  end
endmodule

// File: doc/weight_update.md
Name: weight_update

Overview:
Sign-error LMS coefficient update stage for the adaptive filter datapath. It sits directly downstream of the error subtractor and consumes its error sample. It holds the input-sample tap delay line and the TAPS coefficient registers. On each accepted error it sequentially updates one tap per cycle, w[k] += sign(e)·(x[k] >>> MU_SHIFT), and exposes coefficients through a read port to the filter stage.

Parameters:
WIDTH, 16, sample/error/weight width (signed two's complement)
TAPS, 8, number of filter taps (>=2)
ADDR_W, 3, weight read address width (2^ADDR_W >= TAPS)
MU_SHIFT, 4, step size = 2^-MU_SHIFT, applied as an arithmetic right shift
LEAK_SHIFT, 8, leakage factor 2^-LEAK_SHIFT; used only when WU_LEAKAGE_EN is defined

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
x_in  in  WIDTH  new input sample
x_valid  in  1  shift x_in into the delay line when x_ready=1
x_ready  out  1  delay line can accept a sample (high in IDLE)
error  in  WIDTH  error sample from the error stage
err_valid  in  1  error sample valid
err_ready  out  1  update engine idle, error accepted on err_valid&err_ready
w_addr  in  ADDR_W  coefficient read address
w_data  out  WIDTH  coefficient w[w_addr], combinational
busy  out  1  update in progress (state != IDLE)
update_done  out  1  one-cycle pulse at end of a full update pass

Behaviour:
- Reset (async, any time): all w[k]=0, all xd[k]=0, state=IDLE, idx=0, update_done=0. A reset mid-update abandons the pass with no done pulse. After deassertion, x_ready=1, err_ready=1, busy=0.
- Delay line: on x_valid&x_ready, xd[0]<=x_in, xd[k]<=xd[k-1]. xd[0] is the newest sample. x_valid is ignored while x_ready=0; the line is unchanged.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: x_ready=err_ready=1. On err_valid, latch sgn = +1/-1/0 (error>0 / <0 / ==0), idx<=0, go to UPDATE.
  - UPDATE: each cycle, delta = xd[idx] >>> MU_SHIFT (sign-extended). w[idx] <= sat(w[idx] + delta) for sgn=+1, sat(w[idx] - delta) for sgn=-1, unchanged for sgn=0. Then idx++. When idx==TAPS-1, go to DONE.
  - DONE: update_done=1 for this single cycle, then go to IDLE.
- Arithmetic: sum is formed in WIDTH+1 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. No wrap-around.
- Latency: error accepted at edge N; w[k] is updated at edge N+1+k; update_done is high during the cycle after edge N+TAPS. The next error is accepted no earlier than TAPS+2 cycles after the previous one.
- Simultaneous x_valid and err_valid in IDLE: both are accepted at the same edge. The update uses the post-shift delay line.
- w_data: w[w_addr] combinational. Returns 0 for w_addr >= TAPS. During UPDATE it reflects partially updated contents.
- sgn=0 still runs the full TAPS pass and pulses update_done.

Optional Feature:
WU_LEAKAGE_EN:
- Defined: leaky LMS. Each visited tap computes w_new = sat(w - (w >>> LEAK_SHIFT) ± delta), formed in WIDTH+2 bits before saturation. Leakage applies even when sgn=0.
- Undefined: no leakage term; the LEAK_SHIFT parameter is unused. Timing is identical in both builds.

Test Plan:
1. Reset: pulse rst → all 8 w_data reads = 0, x_ready=1, err_ready=1, busy=0, update_done=0.
2. Shift x=1600 then x=3200, then error=+100 → w[0]=200, w[1]=100, w[2..7]=0. update_done pulses exactly 9 cycles after the accept edge. err_ready=0 for 9 cycles.
3. Same line, error=-5 → w[0]=0, w[1]=0. Then error=0 → all weights unchanged, update_done still pulses.
4. Saturation: x=32767 (delta 2047), 17 updates with error=+1 → w[0]=32752 after 16 updates, 32767 after 17. x=-32768 with error=+1 from w=-32760 → w stays -32768.
5. Backpressure: during busy, drive x_valid with x=999 and err_valid with error=7 → delay line unchanged, error not accepted. The error is accepted the cycle after DONE. Simultaneous x_valid and err_valid in IDLE → update uses new xd[0].
6. Reset mid-update: assert rst at the 3rd UPDATE cycle → all weights 0 immediately, no update_done. With WU_LEAKAGE_EN, preload w[0]=25600 and error=0 → w[0]=25500.
